// File: rtl/pc_gen.sv
// Stage-1 fetch program counter: sequential stepping, ALU and trap redirects,
// and a one-entry buffer that holds a redirect resolved while fetch is stalled.
module pc_gen #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_2000),
    parameter int               STEP     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             PC_Sel,
    input  logic [WIDTH-1:0] ALU_Out,
    input  logic             trap_en,
    input  logic [WIDTH-1:0] trap_vec,
    output logic [WIDTH-1:0] PC_Out,
    output logic [WIDTH-1:0] PC_Next,
    output logic             redirect_pending,
    output logic             misalign_err
);

    // STEP is a power of two, so STEP-1 selects exactly the low ALIGN_BITS;
    // STEP=1 gives an empty mask, which leaves targets untouched and never flags.
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic             misalign_q, misalign_d;

    logic [WIDTH-1:0] alu_aligned, trap_aligned, pend_aligned;
    logic             alu_misaligned, trap_misaligned;

    assign alu_aligned     = ALU_Out & ~LOW_MASK;
    assign trap_aligned    = trap_vec & ~LOW_MASK;
    assign pend_aligned    = pend_addr_q & ~LOW_MASK;
    assign alu_misaligned  = |(ALU_Out & LOW_MASK);
    assign trap_misaligned = |(trap_vec & LOW_MASK);

    always_comb begin
        pc_d         = pc_q + STEP_W;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        misalign_d   = 1'b0;
        if (reset) begin
            pc_d         = RESET_PC;
            pend_valid_d = 1'b0;
            pend_addr_d  = '0;
        end else if (trap_en) begin
            pc_d         = trap_aligned;
            pend_valid_d = 1'b0;
            misalign_d   = trap_misaligned;
        end else if (!stall && PC_Sel) begin
            // A fresh redirect is younger than anything buffered, so it wins.
            pc_d         = alu_aligned;
            pend_valid_d = 1'b0;
            misalign_d   = alu_misaligned;
        end else if (!stall && pend_valid_q) begin
            pc_d         = pend_aligned;
            pend_valid_d = 1'b0;
        end else if (stall && PC_Sel) begin
            pc_d         = pc_q;
            pend_valid_d = 1'b1;
            pend_addr_d  = alu_aligned;
            misalign_d   = alu_misaligned;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        pc_q         <= pc_d;
        pend_valid_q <= pend_valid_d;
        pend_addr_q  <= pend_addr_d;
        misalign_q   <= misalign_d;
    end

    assign PC_Out           = pc_q;
    assign PC_Next          = pc_d;
    assign redirect_pending = pend_valid_q;
    assign misalign_err     = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected PC/pending/misalign values are queued
// when each step is driven and popped once the clock edge has produced output.
module tb_pc_gen;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, PC_Sel, trap_en;
    logic [31:0] ALU_Out, trap_vec;
    logic [31:0] PC_Out, PC_Next;
    logic        redirect_pending, misalign_err;

    logic [7:0]  pc8_out, pc8_next;
    logic        pend8, mis8;

    int   n_asserts = 0;
    int   n_fail    = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .PC_Sel(PC_Sel), .ALU_Out(ALU_Out),
        .trap_en(trap_en), .trap_vec(trap_vec), .PC_Out(PC_Out), .PC_Next(PC_Next),
        .redirect_pending(redirect_pending), .misalign_err(misalign_err)
    );

    pc_gen #(.WIDTH(8), .RESET_PC(8'hF8), .STEP(4)) dut8 (
        .clk(clk), .reset(reset), .stall(1'b0), .PC_Sel(1'b0), .ALU_Out(8'h00),
        .trap_en(1'b0), .trap_vec(8'h00), .PC_Out(pc8_out), .PC_Next(pc8_next),
        .redirect_pending(pend8), .misalign_err(mis8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check PC_Next before the edge, then the
    // registered outputs just after it.
    task automatic step(input string tag, input logic rst, input logic stl,
                        input logic sel, input logic [31:0] alu,
                        input logic trp, input logic [31:0] tv,
                        input logic [31:0] e_pc, input logic e_pend, input logic e_mis);
        exp_t e;
        reset = rst; stall = stl; PC_Sel = sel; ALU_Out = alu; trap_en = trp; trap_vec = tv;
        exp_q.push_back('{pc: e_pc, pend: e_pend, mis: e_mis});
        #1;
        chk({tag, ".next"}, PC_Next, exp_q[0].pc);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".pc"}, PC_Out, e.pc);
        chk({tag, ".pend"}, {31'b0, redirect_pending}, {31'b0, e.pend});
        chk({tag, ".mis"}, {31'b0, misalign_err}, {31'b0, e.mis});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; PC_Sel = 1'b0; trap_en = 1'b0;
        ALU_Out = '0; trap_vec = '0;
        @(negedge clk);

        // reset and sequential increment, with the 8-bit instance wrapping
        step("rst0", 1, 0, 0, 32'h0, 0, 32'h0, 32'h2000, 0, 0);
        step("rst1", 1, 1, 1, 32'h9990, 1, 32'h40, 32'h2000, 0, 0);
        chk("w8.rst", {24'b0, pc8_out}, 32'hF8);
        step("inc0", 0, 0, 0, 32'h0, 0, 32'h0, 32'h2004, 0, 0);
        chk("w8.inc0", {24'b0, pc8_out}, 32'hFC);
        step("inc1", 0, 0, 0, 32'h0, 0, 32'h0, 32'h2008, 0, 0);
        chk("w8.wrap", {24'b0, pc8_out}, 32'h00);

        // direct redirect
        step("dir", 0, 0, 1, 32'h3000, 0, 32'h0, 32'h3000, 0, 0);
        step("dir+", 0, 0, 0, 32'h0, 0, 32'h0, 32'h3004, 0, 0);

        // stalled redirect buffered then applied
        step("st0", 0, 1, 1, 32'h4000, 0, 32'h0, 32'h3004, 1, 0);
        step("st1", 0, 1, 0, 32'h0, 0, 32'h0, 32'h3004, 1, 0);
        step("st2", 0, 1, 0, 32'h0, 0, 32'h0, 32'h3004, 1, 0);
        step("stgo", 0, 0, 0, 32'h0, 0, 32'h0, 32'h4000, 0, 0);
        step("stgo+", 0, 0, 0, 32'h0, 0, 32'h0, 32'h4004, 0, 0);

        // trap during a stall flushes the pending buffer
        step("tp0", 0, 1, 1, 32'h4000, 0, 32'h0, 32'h4004, 1, 0);
        step("trap", 0, 1, 0, 32'h0, 1, 32'h0100, 32'h0100, 0, 0);
        step("trap+", 0, 0, 0, 32'h0, 0, 32'h0, 32'h0104, 0, 0);

        // misalignment on ALU and trap targets
        step("mis", 0, 0, 1, 32'h5002, 0, 32'h0, 32'h5000, 0, 1);
        step("mis+", 0, 0, 0, 32'h0, 0, 32'h0, 32'h5004, 0, 0);
        step("al", 0, 0, 1, 32'h6000, 0, 32'h0, 32'h6000, 0, 0);
        step("tmis", 0, 0, 1, 32'h7777, 1, 32'h0102, 32'h0100, 0, 1);
        step("tmis+", 0, 0, 0, 32'h0, 0, 32'h0, 32'h0104, 0, 0);

        // new PC_Sel beats an older buffered target
        step("nw0", 0, 1, 1, 32'h7000, 0, 32'h0, 32'h0104, 1, 0);
        step("nw1", 0, 0, 1, 32'h8000, 0, 32'h0, 32'h8000, 0, 0);
        step("nw2", 0, 0, 0, 32'h0, 0, 32'h0, 32'h8004, 0, 0);

        // newer stalled request overwrites the buffer
        step("ow0", 0, 1, 1, 32'h9000, 0, 32'h0, 32'h8004, 1, 0);
        step("ow1", 0, 1, 1, 32'hA000, 0, 32'h0, 32'h8004, 1, 0);
        step("ow2", 0, 0, 0, 32'h0, 0, 32'h0, 32'hA000, 0, 0);
        step("ow3", 0, 0, 0, 32'h0, 0, 32'h0, 32'hA004, 0, 0);

        // misaligned stalled request flags at acceptance, not at apply
        step("sm0", 0, 1, 1, 32'hB001, 0, 32'h0, 32'hA004, 1, 1);
        step("sm1", 0, 0, 0, 32'h0, 0, 32'h0, 32'hB000, 0, 0);

        // reset while pending discards the buffered target
        step("mr0", 0, 1, 1, 32'hC000, 0, 32'h0, 32'hB000, 1, 0);
        step("mr1", 1, 0, 0, 32'h0, 0, 32'h0, 32'h2000, 0, 0);
        step("mr2", 0, 0, 0, 32'h0, 0, 32'h0, 32'h2004, 0, 0);
        step("mr3", 0, 0, 0, 32'h0, 0, 32'h0, 32'h2008, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
